aes_inv_round_iter: RTL and testbench
=====================================

Name: aes_inv_round_iter

Overview:
- Iterative AES-128 inverse cipher (decryption) datapath, mirroring the encryption round chain.
- Completes one round per clock: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
- Fetches round keys from the existing expanded-key store through a combinational index/read port.
- Sits between the ciphertext source and the plaintext consumer, with valid/ready handshakes on both sides.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported.
- RK_IDX_W, 4, width of the round-key index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext valid.
- in_ready  output  1  core can accept a block.
- ct_in  input  128  ciphertext block; byte0 = [127:120], column-major state (FIPS-197).
- rk_idx  output  RK_IDX_W  round-key index requested this cycle.
- rk  input  128  round key for rk_idx, returned combinationally in the same cycle.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  consumer accepts plaintext.
- pt_out  output  128  plaintext block, same byte order as ct_in.
- busy  output  1  high in any state except IDLE.

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, pt_out=0, rk_idx=10, round counter=9.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - rk_idx=10, in_ready=1.
  - On in_valid, the block is accepted at that edge: state_reg <= ct_in ^ rk, round counter <= 9, go to ROUND.
- ROUND:
  - rk_idx = round counter.
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk).
  - If counter==1, go to FINAL; otherwise decrement the counter.
  - Runs 9 cycles, for indices 9..1.
- FINAL:
  - rk_idx=0.
  - pt_out <= InvSubBytes(InvShiftRows(state_reg)) ^ rk.
  - out_valid <= 1, go to DONE.
- DONE:
  - pt_out and out_valid are held stable.
  - On out_ready, out_valid <= 0 and go to IDLE. in_ready rises the next cycle; there is no same-cycle bypass.
- Latency: acceptance at edge T gives out_valid=1 after edge T+10 (11 edges including acceptance). Throughput is 1 block per 12 cycles when out_ready is held high.
- in_ready is 0 in ROUND, FINAL and DONE. in_valid in those states is ignored and does not corrupt the data in flight.
- out_ready while out_valid=0 has no effect.
- InvShiftRows: row r is rotated right by r byte positions (r = 0..3).
- InvSubBytes: FIPS-197 inverse S-box on all 16 bytes. Implemented as 16 combinational instances of an inverse S-box lookup submodule.
- InvMixColumns: per column, matrix [0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e] over GF(2^8) with polynomial 0x11B; xtime is used, with no multipliers.
- All datapath widths are exactly 8 bits per byte and 128 bits per state; there is no truncation anywhere.
- Reset mid-operation (any state) returns to IDLE on the next edge. The partial state is discarded, out_valid=0, and the next block starts clean.
- rk_idx is driven combinationally from the FSM state and counter. It must be stable before the edge that consumes rk.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: key store holds the expansion of key 000102030405060708090a0b0c0d0e0f; drive ct_in=69c4e0d86a7b0430d8cdb78070b4c55a with out_ready=1.
  - Required: pt_out=00112233445566778899aabbccddeeff, out_valid rising 10 edges after acceptance.
- rk_idx sequence:
  - Stimulus: same run as the C.1 vector.
  - Required: rk_idx observed as 10 (IDLE/accept), then 9,8,...,1 (ROUND), then 0 (FINAL), then 10 again back in IDLE.
- Output stall:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Required: pt_out and out_valid stay constant and in_ready stays 0; releasing out_ready gives one acceptance, then in_ready=1 the following cycle.
- in_valid while busy:
  - Stimulus: pulse in_valid with ct_in=ffff...ff during ROUND.
  - Required: no acceptance, and the in-flight C.1 result is unchanged.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during round 5, then submit the C.1 vector again.
  - Required: out_valid=0 and in_ready=1 right after reset; correct plaintext afterwards.
- Back-to-back blocks:
  - Stimulus: two blocks, the C.1 ciphertext and then the encryption of 0 under the same key, with in_valid held high and out_ready=1.
  - Required: both plaintexts correct and in order; the second is accepted one cycle after the first out_valid handshake.

Source files
------------

// File: rtl/aes_inv_round_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Round keys are fetched combinationally from an external key store.
module aes_inv_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   localparam logic [0:255][7:0] INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   assign y_o = INV[a_i];
endmodule

module aes_inv_round_iter #(
   parameter int NR       = 10,
   parameter int RK_IDX_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        ct_in,
   output logic [RK_IDX_W-1:0] rk_idx,
   input  logic [127:0]        rk,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        pt_out,
   output logic                busy
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUND,
      S_FINAL,
      S_DONE
   } st_e;

   st_e                 state_q, state_d;
   logic [RK_IDX_W-1:0] cnt_q, cnt_d;
   logic [127:0]        data_q, data_d;
   logic [127:0]        pt_q, pt_d;
   logic                ov_q, ov_d;

   logic [127:0] isr, isb, ark, imc;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte (r,c) lives at s[127-8*(4c+r) -: 8]; row r rotates right by r.
   function automatic logic [127:0] inv_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a [4];
      logic [7:0]   x2 [4];
      logic [7:0]   x4 [4];
      logic [7:0]   x8 [4];
      logic [7:0]   m9 [4];
      logic [7:0]   mb [4];
      logic [7:0]   md [4];
      logic [7:0]   me [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            a[r]  = s[127-8*(4*c+r) -: 8];
            x2[r] = xt(a[r]);
            x4[r] = xt(x2[r]);
            x8[r] = xt(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
         end
         o[127-32*c -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         o[119-32*c -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         o[111-32*c -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         o[103-32*c -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end
      return o;
   endfunction

   assign isr = inv_shift(data_q);

   for (genvar i = 0; i < 16; i++) begin : g_sb
      aes_inv_sbox u_sb (
         .a_i (isr[8*i +: 8]),
         .y_o (isb[8*i +: 8])
      );
   end

   assign ark = isb ^ rk;
   assign imc = inv_mix(ark);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= RK_IDX_W'(NR - 1);
         data_q  <= '0;
         pt_q    <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         pt_q    <= pt_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      pt_d    = pt_q;
      ov_d    = ov_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               data_d  = ct_in ^ rk;
               cnt_d   = RK_IDX_W'(NR - 1);
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            data_d = imc;
            if (cnt_q == RK_IDX_W'(1)) state_d = S_FINAL;
            else cnt_d = cnt_q - RK_IDX_W'(1);
         end
         S_FINAL: begin
            pt_d    = ark;
            ov_d    = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == S_IDLE);
      busy     = (state_q != S_IDLE);
      rk_idx   = RK_IDX_W'(NR);
      unique case (state_q)
         S_ROUND: rk_idx = cnt_q;
         S_FINAL: rk_idx = '0;
         default: rk_idx = RK_IDX_W'(NR);
      endcase
   end

   assign out_valid = ov_q;
   assign pt_out    = pt_q;
endmodule

// File: tb/tb_aes_inv_round_iter.sv
// Directed bench for aes_inv_round_iter with a forward-cipher
// reference model and an expected-plaintext scoreboard.
module tb_aes_inv_round_iter;
   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ct_in;
   logic [3:0]   rk_idx;
   logic [127:0] rk;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] pt_out;
   logic         busy;

   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;

   localparam logic [127:0] RKT [11] = '{
      128'h000102030405060708090a0b0c0d0e0f,
      128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
      128'hb692cf0b643dbdf1be9bc5006830b3fe,
      128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
      128'h47f7f7bc95353e03f96c32bcfd058dfd,
      128'h3caaa3e8a99f9deb50f3af57adf622aa,
      128'h5e390f7df7a69296a7553dc10aa31f6b,
      128'h14f9701ae35fe28c440adf4d4ea9c026,
      128'h47438735a41c65b9e016baf4aebf7ad2,
      128'h549932d1f08557681093ed9cbe2c974e,
      128'h13111d7fe3944a17f307a78b4d2b30c5
   };

   localparam logic [0:255][7:0] SB = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   int           checks;
   int           failures;
   int           cyc;
   int           acc_edge;
   int           hs_edge;
   int           n_hs;
   int           h0;
   logic         ov_prev;
   logic [127:0] cur_exp;
   logic [127:0] c0;
   logic [127:0] exp_q [$];

   aes_inv_round_iter #(
      .NR       (10),
      .RK_IDX_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ct_in     (ct_in),
      .rk_idx    (rk_idx),
      .rk        (rk),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt_out    (pt_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      rk = '0;
      if (rk_idx < 4'd11) rk = RKT[rk_idx];
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = SB[s[127-8*(4*((c+r)%4)+r) -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] p);
      logic [127:0] s;
      s = p ^ RKT[0];
      for (int r = 1; r < 10; r++) s = mix(sub_shift(s)) ^ RKT[r];
      return sub_shift(s) ^ RKT[10];
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ov();
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      chk("ov_timeout", 128'(out_valid), 128'(1));
   endtask

   // Scoreboard: push on accept, pop and compare on output handshake.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            acc_edge = cyc + 1;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_empty", 128'(1), 128'(0));
            else chk("pt_out", pt_out, exp_q.pop_front());
            hs_edge = cyc + 1;
            n_hs++;
         end
         if (out_valid && !ov_prev)
            chk("latency", 128'(cyc - acc_edge), 128'(10));
      end
      ov_prev = out_valid;
   end

   initial begin
      checks = 0; failures = 0; cyc = 0; n_hs = 0;
      acc_edge = 0; hs_edge = 0; ov_prev = 1'b0;
      rst = 1'b1; in_valid = 1'b0; ct_in = '0;
      out_ready = 1'b1; cur_exp = '0;
      c0 = aes_enc('0);
      step(); step();
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_pt_out", pt_out, 128'(0));
      chk("rst_rk_idx", 128'(rk_idx), 128'(10));
      rst = 1'b0;
      step();

      // C.1 vector with rk_idx walk
      ct_in = C1; cur_exp = P1; in_valid = 1'b1;
      chk("idx_accept", 128'(rk_idx), 128'(10));
      chk("in_ready_idle", 128'(in_ready), 128'(1));
      step();
      in_valid = 1'b0;
      chk("busy_round", 128'(busy), 128'(1));
      for (int k = 9; k >= 1; k--) begin
         chk("idx_round", 128'(rk_idx), 128'(k));
         step();
      end
      chk("idx_final", 128'(rk_idx), 128'(0));
      step();
      chk("ov_done", 128'(out_valid), 128'(1));
      step();
      chk("idx_back", 128'(rk_idx), 128'(10));
      chk("ready_back", 128'(in_ready), 128'(1));
      chk("hs_c1", 128'(n_hs), 128'(1));

      // in_valid while busy must be ignored
      ct_in = C1; cur_exp = P1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      ct_in = '1; in_valid = 1'b1;
      chk("busy_no_ready", 128'(in_ready), 128'(0));
      step(); step();
      in_valid = 1'b0; ct_in = '0;
      wait_ov();
      step();
      chk("hs_busy", 128'(n_hs), 128'(2));

      // Output stall
      out_ready = 1'b0;
      ct_in = C1; cur_exp = P1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_ov();
      h0 = n_hs;
      for (int i = 0; i < 20; i++) begin
         chk("stall_ov", 128'(out_valid), 128'(1));
         chk("stall_rdy", 128'(in_ready), 128'(0));
         chk("stall_pt", pt_out, P1);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("rel_ov", 128'(out_valid), 128'(0));
      chk("rel_rdy", 128'(in_ready), 128'(1));
      step(); step();
      chk("rel_one_hs", 128'(n_hs), 128'(h0 + 1));

      // Reset during round 5
      ct_in = C1; cur_exp = P1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      chk("pre_rst_idx", 128'(rk_idx), 128'(5));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_ov", 128'(out_valid), 128'(0));
      chk("mid_rst_rdy", 128'(in_ready), 128'(1));
      chk("mid_rst_busy", 128'(busy), 128'(0));
      h0 = n_hs;
      ct_in = C1; cur_exp = P1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_ov();
      step();
      chk("post_rst_hs", 128'(n_hs), 128'(h0 + 1));

      // Back-to-back blocks
      h0 = n_hs;
      ct_in = C1; cur_exp = P1; in_valid = 1'b1;
      step();
      ct_in = c0; cur_exp = '0;
      wait_ov();
      step();
      step();
      in_valid = 1'b0;
      chk("b2b_gap", 128'(acc_edge), 128'(hs_edge + 1));
      wait_ov();
      step();
      chk("b2b_hs", 128'(n_hs), 128'(h0 + 2));
      step();
      chk("sb_drained", 128'(exp_q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
